pe_column_buf: RTL and testbench

- Parametrised next-generation PE column: NUM_PE multiply-accumulate PEs chained vertically; srcb and clear ripple down the chain one stage per PE.
- Per-lane psums are assembled into one output word and pushed into an internal FIFO.
- The FIFO presents words on a valid/ready stream toward the output global buffer.
- New relative to the previous generation: arbitrary lane count and width, per-column saturation mode, backpressure-tolerant output buffering, and overflow/spacing error flags.

---
 rtl/pe_column_buf.sv | 250 +++++++++++++++++++++++++
 tb/tb_pe_column_buf.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_column_buf.sv
// ---------------------------------------------------------------------------
// pe_column_buf
//   A column of NUM_PE multiply-accumulate PEs. The B operand and the
//   start-of-tile clear ripple down the column one PE per cycle. The caller
//   skews the A operands so that PE k sees its lane of srca_word_i in the
//   same cycle as the B/clear values that reach it. When a tile ends (we_i),
//   the per-lane partial sums are collected into one word and pushed into a
//   small output FIFO. That FIFO drives a valid/ready stream.
//
// Ports
//   clk_i, rst_ni      clock, synchronous active-low reset
//   sat_i              1 = saturating accumulate, 0 = wrap-around
//   clr_i / clr_o      start-of-tile clear into PE0 / delayed 1 cycle
//   we_i  / we_o       last-operand marker into PE0 / delayed 1 cycle
//   srca_word_i / _o   per-lane A operands / delayed 1 cycle
//   srcb_i / srcb_o    B operand into PE0 / leaving the last PE (NUM_PE cycles)
//   m_data_o, m_valid_o, m_ready_i   output word stream (FIFO head)
//   full_o             FIFO full
//   ovf_o              sticky: a finished word was dropped (FIFO full)
//   err_o              sticky: we_i pulses spaced closer than NUM_PE cycles
// ---------------------------------------------------------------------------
module pe_column_buf #(
    parameter int NUM_PE     = 8,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         sat_i,
    input  logic                         clr_i,
    output logic                         clr_o,
    input  logic                         we_i,
    output logic                         we_o,
    input  logic [NUM_PE*DATA_WIDTH-1:0] srca_word_i,
    output logic [NUM_PE*DATA_WIDTH-1:0] srca_word_o,
    input  logic [DATA_WIDTH-1:0]        srcb_i,
    output logic [DATA_WIDTH-1:0]        srcb_o,
    output logic [NUM_PE*DATA_WIDTH-1:0] m_data_o,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic                         full_o,
    output logic                         ovf_o,
    output logic                         err_o
);

    localparam int W      = DATA_WIDTH;
    localparam int PW     = 2 * DATA_WIDTH;
    localparam int WORD_W = NUM_PE * DATA_WIDTH;
    localparam int AW     = $clog2(FIFO_DEPTH);

    // Clamp limits expressed in the 2W+1 intermediate width.
    localparam logic signed [PW:0] SAT_MAX = {{(PW + 2 - W){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [PW:0] SAT_MIN = {{(PW + 2 - W){1'b1}}, {(W - 1){1'b0}}};

    logic [W-1:0]      b_chain   [NUM_PE];
    logic [NUM_PE-1:0] clr_chain;
    logic [W-1:0]      psum_lane [NUM_PE];
    logic [W-1:0]      stage_lane[NUM_PE-1];

    // we_sr_reg[j] holds we_i from j+1 cycles ago. Together with we_i itself
    // this gives NUM_PE+2 taps. Lane k is captured at tap k+2, and the word
    // is pushed at tap NUM_PE+1.
    logic [NUM_PE:0] we_sr_reg;

    logic [WORD_W-1:0] srca_word_reg;
    logic [WORD_W-1:0] push_word;

    // ------------------------------------------------------------------
    // PE chain
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe
        logic signed [W-1:0]  a_in;
        logic signed [W-1:0]  b_in;
        logic                 clr_in;
        logic [W-1:0]         b_reg;
        logic                 clr_reg;
        logic signed [PW-1:0] prod_reg;
        logic signed [PW-1:0] prod_next;
        logic                 clrp_reg;
        logic signed [W-1:0]  psum_reg;
        logic signed [W-1:0]  psum_next;
        logic signed [PW:0]   prod_ext;
        logic signed [PW:0]   psum_ext;
        logic signed [PW:0]   sum_wide;

        if (gi == 0) begin : g_head
            assign b_in   = srcb_i;
            assign clr_in = clr_i;
        end else begin : g_tail
            assign b_in   = b_chain[gi-1];
            assign clr_in = clr_chain[gi-1];
        end

        assign a_in = srca_word_i[gi*W +: W];

        // Sign-extend to 2W before multiplying. The low 2W bits of the
        // product are then the exact signed product.
        assign prod_next = {{W{a_in[W-1]}}, a_in} * {{W{b_in[W-1]}}, b_in};

        assign prod_ext = {prod_reg[PW-1], prod_reg};
        assign psum_ext = {{(PW + 1 - W){psum_reg[W-1]}}, psum_reg};

        always_comb begin
            sum_wide = prod_ext;
            if (!clrp_reg) begin
                sum_wide = psum_ext + prod_ext;
            end
        end

        // The clear path goes through the same wrap/clamp as accumulation.
        always_comb begin
            psum_next = sum_wide[W-1:0];
            if (sat_i) begin
                if (sum_wide > SAT_MAX) begin
                    psum_next = SAT_MAX[W-1:0];
                end else if (sum_wide < SAT_MIN) begin
                    psum_next = SAT_MIN[W-1:0];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                b_reg    <= '0;
                clr_reg  <= 1'b0;
                prod_reg <= '0;
                clrp_reg <= 1'b0;
                psum_reg <= '0;
            end else begin
                b_reg    <= b_in;
                clr_reg  <= clr_in;
                prod_reg <= prod_next;
                clrp_reg <= clr_in;
                psum_reg <= psum_next;
            end
        end

        assign b_chain[gi]   = b_reg;
        assign clr_chain[gi] = clr_reg;
        assign psum_lane[gi] = psum_reg;
    end

    // ------------------------------------------------------------------
    // Staging: lanes 0..NUM_PE-2 are held until the last lane finishes.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_PE - 1; gi++) begin : g_stage
        logic [W-1:0] stage_reg;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                stage_reg <= '0;
            end else if (we_sr_reg[gi+1]) begin
                stage_reg <= psum_lane[gi];
            end
        end

        assign stage_lane[gi] = stage_reg;
    end

    // The last lane finishes in the push cycle itself, so it bypasses staging.
    always_comb begin
        push_word = '0;
        for (int k = 0; k < NUM_PE - 1; k++) begin
            push_word[k*W +: W] = stage_lane[k];
        end
        push_word[(NUM_PE-1)*W +: W] = psum_lane[NUM_PE-1];
    end

    // ------------------------------------------------------------------
    // we shift register, pass-through registers, spacing check
    // ------------------------------------------------------------------
    logic spacing_viol;
    assign spacing_viol = we_i && (|we_sr_reg[NUM_PE-2:0]);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            we_sr_reg     <= '0;
            srca_word_reg <= '0;
        end else begin
            we_sr_reg     <= {we_sr_reg[NUM_PE-1:0], we_i};
            srca_word_reg <= srca_word_i;
        end
    end

    assign we_o        = we_sr_reg[0];
    assign clr_o       = clr_chain[0];
    assign srcb_o      = b_chain[NUM_PE-1];
    assign srca_word_o = srca_word_reg;

    // ------------------------------------------------------------------
    // Output FIFO. The pointers carry an extra wrap bit so that full and
    // empty can be told apart.
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] mem_reg [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_reg;
    logic [AW:0]       rd_ptr_reg;
    logic              ovf_reg;
    logic              err_reg;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push_req;
    logic              push;
    logic              pop;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign pop      = !fifo_empty && m_ready_i;
    assign push_req = we_sr_reg[NUM_PE];
    // When the FIFO is full, a push still fits if the head leaves on the same edge.
    assign push     = push_req && (!fifo_full || pop);

    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= push_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            ovf_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_req && !push) begin
                ovf_reg <= 1'b1;
            end
            if (spacing_viol) begin
                err_reg <= 1'b1;
            end
        end
    end

    // The head is forced to zero when the FIFO is empty, so stale RAM
    // contents never show on the stream.
    assign m_data_o  = fifo_empty ? '0 : mem_reg[rd_ptr_reg[AW-1:0]];
    assign m_valid_o = !fifo_empty;
    assign full_o    = fifo_full;
    assign ovf_o     = ovf_reg;
    assign err_o     = err_reg;

endmodule

// File: tb/tb_pe_column_buf.sv
// ---------------------------------------------------------------------------
// tb_pe_column_buf
//   Each test fills a cycle-indexed schedule of input values. A tile is
//   described as a list of operand steps. The bench adds the B/clear skew
//   and the A skew itself. Expected words come from an arithmetic fold of
//   the tile's a*b products with the wrap or clamp rule. The schedule is
//   then played, and the outputs and popped words are recorded per cycle.
// ---------------------------------------------------------------------------
module tb_pe_column_buf;

    localparam int NUM_PE = 8;
    localparam int W      = 16;
    localparam int DEPTH  = 2;
    localparam int WORD_W = NUM_PE * W;
    localparam int MAXC   = 96;
    localparam int MAXL   = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              sat_i;
    logic              clr_i;
    logic              clr_o;
    logic              we_i;
    logic              we_o;
    logic [WORD_W-1:0] srca_word_i;
    logic [WORD_W-1:0] srca_word_o;
    logic [W-1:0]      srcb_i;
    logic [W-1:0]      srcb_o;
    logic [WORD_W-1:0] m_data_o;
    logic              m_valid_o;
    logic              m_ready_i;
    logic              full_o;
    logic              ovf_o;
    logic              err_o;

    always #5 clk_i = ~clk_i;

    pe_column_buf #(
        .NUM_PE    (NUM_PE),
        .DATA_WIDTH(W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .sat_i      (sat_i),
        .clr_i      (clr_i),
        .clr_o      (clr_o),
        .we_i       (we_i),
        .we_o       (we_o),
        .srca_word_i(srca_word_i),
        .srca_word_o(srca_word_o),
        .srcb_i     (srcb_i),
        .srcb_o     (srcb_o),
        .m_data_o   (m_data_o),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .full_o     (full_o),
        .ovf_o      (ovf_o),
        .err_o      (err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // input schedule
    logic         s_rst  [MAXC];
    logic         s_clr  [MAXC];
    logic         s_we   [MAXC];
    logic         s_ready[MAXC];
    logic [W-1:0] s_b    [MAXC];
    logic [W-1:0] s_a    [NUM_PE][MAXC];

    // observations per cycle
    logic              o_valid[MAXC];
    logic              o_full [MAXC];
    logic              o_ovf  [MAXC];
    logic              o_err  [MAXC];
    logic              o_we   [MAXC];
    logic              o_clr  [MAXC];
    logic [W-1:0]      o_srcb [MAXC];
    logic [WORD_W-1:0] o_srca [MAXC];
    logic [WORD_W-1:0] o_data [MAXC];
    logic [WORD_W-1:0] pop_q[$];

    int tile_a[NUM_PE][MAXL];
    int tile_b[MAXL];
    bit cur_sat;

    function automatic longint fix_val(input longint v, input bit sat);
        longint lim;
        longint r;
        lim = longint'(1) << (W - 1);
        if (sat) begin
            if (v > lim - 1)   r = lim - 1;
            else if (v < -lim) r = -lim;
            else               r = v;
        end else begin
            r = v & ((lim << 1) - 1);
            if (r >= lim) r = r - (lim << 1);
        end
        return r;
    endfunction

    task automatic clear_sched();
        for (int c = 0; c < MAXC; c++) begin
            s_rst[c]   = 1'b1;
            s_clr[c]   = 1'b0;
            s_we[c]    = 1'b0;
            s_ready[c] = 1'b1;
            s_b[c]     = '0;
            for (int k = 0; k < NUM_PE; k++) s_a[k][c] = '0;
        end
        pop_q.delete();
    endtask

    task automatic fill_const(input int len, input int a, input int b);
        for (int j = 0; j < len; j++) begin
            tile_b[j] = b;
            for (int k = 0; k < NUM_PE; k++) tile_a[k][j] = a;
        end
    endtask

    task automatic fill_rand(input int len);
        logic signed [W-1:0] tmp;
        for (int j = 0; j < len; j++) begin
            tmp = W'($urandom());
            tile_b[j] = int'(tmp);
            for (int k = 0; k < NUM_PE; k++) begin
                tmp = W'($urandom());
                tile_a[k][j] = int'(tmp);
            end
        end
    endtask

    // Place a tile in the schedule and compute its expected output word.
    task automatic add_tile(input int start, input int len, output logic [WORD_W-1:0] exp_word);
        longint acc;
        longint p;
        exp_word = '0;
        for (int j = 0; j < len; j++) begin
            s_b[start+j] = W'(tile_b[j]);
            for (int k = 0; k < NUM_PE; k++) s_a[k][start+j+k] = W'(tile_a[k][j]);
        end
        s_clr[start]         = 1'b1;
        s_we[start+len-1]    = 1'b1;
        for (int k = 0; k < NUM_PE; k++) begin
            acc = 0;
            for (int j = 0; j < len; j++) begin
                p   = longint'(tile_a[k][j]) * longint'(tile_b[j]);
                acc = fix_val((j == 0) ? p : acc + p, cur_sat);
            end
            exp_word[k*W +: W] = W'(acc);
        end
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        sat_i       = 1'b0;
        clr_i       = 1'b0;
        we_i        = 1'b0;
        srca_word_i = '0;
        srcb_i      = '0;
        m_ready_i   = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    // Play n cycles of the schedule; entered and left 1 time unit after a posedge.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            rst_ni    = s_rst[c];
            clr_i     = s_clr[c];
            we_i      = s_we[c];
            sat_i     = cur_sat;
            srcb_i    = s_b[c];
            m_ready_i = s_ready[c];
            for (int k = 0; k < NUM_PE; k++) srca_word_i[k*W +: W] = s_a[k][c];
            #1;
            o_valid[c] = m_valid_o;
            o_full[c]  = full_o;
            o_ovf[c]   = ovf_o;
            o_err[c]   = err_o;
            o_we[c]    = we_o;
            o_clr[c]   = clr_o;
            o_srcb[c]  = srcb_o;
            o_srca[c]  = srca_word_o;
            o_data[c]  = m_data_o;
            if (m_valid_o && m_ready_i && rst_ni) pop_q.push_back(m_data_o);
            @(posedge clk_i);
            #1;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [WORD_W-1:0] e;
        do_reset();
        clear_sched();
        cur_sat = 1'b0;
        fill_const(4, 2, 3);
        add_tile(1, 4, e);
        for (int c = 0; c < MAXC; c++) s_ready[c] = 1'b0;
        for (int c = 0; c < 20; c++) s_b[c] = W'(c + 1);
        run(20);
        n_checks++;
        if (o_valid[19] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_valid: got %0b expected 1", o_valid[19]);
        end
        do_reset();
        #1;
        n_checks++;
        if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", m_valid_o); end
        n_checks++;
        if (full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", full_o); end
        n_checks++;
        if (ovf_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got ovf=%0b err=%0b expected 0 0", ovf_o, err_o);
        end
        n_checks++;
        if (srcb_o !== '0 || m_data_o !== '0) begin
            n_fail++; $display("FAIL reset_data: got srcb=%0h data=%0h expected 0 0", srcb_o, m_data_o);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_single_tile();
        logic [WORD_W-1:0] e;
        logic [W-1:0]      lane;
        int                first;
        do_reset();
        clear_sched();
        cur_sat = 1'b0;
        fill_const(4, 2, 3);
        add_tile(1, 4, e);
        run(24);
        first = -1;
        for (int c = 23; c >= 0; c--) if (o_valid[c]) first = c;
        n_checks++;
        if (first !== 14) begin n_fail++; $display("FAIL single_latency: got cycle %0d expected 14", first); end
        lane = 16'h0018;
        n_checks++;
        if (o_data[14] !== {NUM_PE{lane}}) begin
            n_fail++; $display("FAIL single_data: got %0h expected %0h", o_data[14], {NUM_PE{lane}});
        end
        n_checks++;
        if (o_valid[15] !== 1'b0) begin n_fail++; $display("FAIL single_popped: got %0b expected 0", o_valid[15]); end
    endtask

    task automatic test_wrap_sat();
        logic [W-1:0]      lane;
        logic [WORD_W-1:0] e;
        logic [WORD_W-1:0] got;
        int                av;
        for (int i = 0; i < 3; i++) begin
            do_reset();
            clear_sched();
            cur_sat = (i != 0);
            av      = (i == 2) ? -200 : 200;
            lane    = (i == 0) ? 16'd14464 : ((i == 1) ? 16'h7FFF : 16'h8000);
            fill_const(2, av, 200);
            add_tile(1, 2, e);
            run(20);
            got = (pop_q.size() > 0) ? pop_q[0] : '0;
            n_checks++;
            if (pop_q.size() != 1 || got !== {NUM_PE{lane}}) begin
                n_fail++;
                $display("FAIL wrap_sat_%0d: got %0h (%0d words) expected %0h", i, got, pop_q.size(), {NUM_PE{lane}});
            end
        end
    endtask

    task automatic test_random();
        logic [WORD_W-1:0] e;
        logic [WORD_W-1:0] exp_q[$];
        logic [WORD_W-1:0] srca_exp;
        int                len;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            clear_sched();
            exp_q.delete();
            cur_sat = (r == 1);
            for (int i = 0; i < 4; i++) begin
                len = $urandom_range(1, 6);
                fill_rand(len);
                add_tile(1 + 14 * i, len, e);
                exp_q.push_back(e);
            end
            for (int c = 0; c < MAXC; c++) s_ready[c] = ((c % 4) == 0) || ($urandom_range(0, 1) == 1);
            run(80);
            n_checks++;
            if (pop_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL random_count_%0d: got %0d expected %0d", r, pop_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < pop_q.size(); i++) begin
                n_checks++;
                if (pop_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL random_word_%0d_%0d: got %0h expected %0h", r, i, pop_q[i], exp_q[i]);
                end
            end
            n_checks++;
            if (o_ovf[79] !== 1'b0 || o_err[79] !== 1'b0) begin
                n_fail++; $display("FAIL random_flags_%0d: got ovf=%0b err=%0b expected 0 0", r, o_ovf[79], o_err[79]);
            end
            // pass-through delays
            for (int c = 0; c < 80; c++) begin
                for (int k = 0; k < NUM_PE; k++) srca_exp[k*W +: W] = (c >= 1) ? s_a[k][c-1] : '0;
                n_checks++;
                if (o_srca[c] !== srca_exp || o_we[c] !== ((c >= 1) ? s_we[c-1] : 1'b0) ||
                    o_clr[c] !== ((c >= 1) ? s_clr[c-1] : 1'b0)) begin
                    n_fail++;
                    $display("FAIL passthru_%0d: got we=%0b clr=%0b srca=%0h expected we=%0b clr=%0b srca=%0h", c,
                             o_we[c], o_clr[c], o_srca[c], (c >= 1) ? s_we[c-1] : 1'b0,
                             (c >= 1) ? s_clr[c-1] : 1'b0, srca_exp);
                end
                n_checks++;
                if (o_srcb[c] !== ((c >= NUM_PE) ? s_b[c-NUM_PE] : '0)) begin
                    n_fail++;
                    $display("FAIL srcb_delay_%0d: got %0h expected %0h", c, o_srcb[c],
                             (c >= NUM_PE) ? s_b[c-NUM_PE] : '0);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WORD_W-1:0] w1;
        logic [WORD_W-1:0] w2;
        logic [WORD_W-1:0] w3;
        do_reset();
        clear_sched();
        cur_sat = 1'b0;
        fill_rand(4); add_tile(1, 4, w1);
        fill_rand(4); add_tile(9, 4, w2);
        fill_rand(4); add_tile(17, 4, w3);
        for (int c = 0; c < MAXC; c++) s_ready[c] = (c >= 34);
        run(40);
        n_checks++;
        if (o_valid[13] !== 1'b0 || o_valid[14] !== 1'b1) begin
            n_fail++; $display("FAIL bp_valid_rise: got %0b%0b expected 01", o_valid[13], o_valid[14]);
        end
        n_checks++;
        if (o_full[21] !== 1'b0 || o_full[22] !== 1'b1) begin
            n_fail++; $display("FAIL bp_full: got %0b%0b expected 01", o_full[21], o_full[22]);
        end
        n_checks++;
        if (o_ovf[29] !== 1'b0 || o_ovf[30] !== 1'b1) begin
            n_fail++; $display("FAIL bp_ovf: got %0b%0b expected 01", o_ovf[29], o_ovf[30]);
        end
        n_checks++;
        if (o_data[30] !== w1) begin n_fail++; $display("FAIL bp_head_stable: got %0h expected %0h", o_data[30], w1); end
        n_checks++;
        if (pop_q.size() != 2) begin
            n_fail++; $display("FAIL bp_pop_count: got %0d expected 2", pop_q.size());
        end else if (pop_q[0] !== w1 || pop_q[1] !== w2) begin
            n_fail++; $display("FAIL bp_pop_order: got %0h %0h expected %0h %0h", pop_q[0], pop_q[1], w1, w2);
        end
        n_checks++;
        if (o_valid[36] !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %0b expected 0", o_valid[36]); end
    endtask

    task automatic test_push_pop_full();
        logic [WORD_W-1:0] w1;
        logic [WORD_W-1:0] w2;
        logic [WORD_W-1:0] w3;
        do_reset();
        clear_sched();
        cur_sat = 1'b1;
        fill_rand(4); add_tile(1, 4, w1);
        fill_rand(4); add_tile(9, 4, w2);
        fill_rand(4); add_tile(17, 4, w3);
        for (int c = 0; c < MAXC; c++) s_ready[c] = (c == 29) || (c >= 33);
        run(42);
        n_checks++;
        if (o_full[30] !== 1'b1) begin n_fail++; $display("FAIL ppf_full: got %0b expected 1", o_full[30]); end
        n_checks++;
        if (o_ovf[41] !== 1'b0) begin n_fail++; $display("FAIL ppf_ovf: got %0b expected 0", o_ovf[41]); end
        n_checks++;
        if (pop_q.size() != 3) begin
            n_fail++; $display("FAIL ppf_pop_count: got %0d expected 3", pop_q.size());
        end else if (pop_q[0] !== w1 || pop_q[1] !== w2 || pop_q[2] !== w3) begin
            n_fail++;
            $display("FAIL ppf_order: got %0h %0h %0h expected %0h %0h %0h", pop_q[0], pop_q[1], pop_q[2], w1, w2, w3);
        end
    endtask

    task automatic test_spacing();
        logic [WORD_W-1:0] w1;
        logic [WORD_W-1:0] got;
        do_reset();
        clear_sched();
        cur_sat = 1'b0;
        fill_rand(4);
        add_tile(1, 4, w1);
        s_we[7] = 1'b1;
        run(30);
        n_checks++;
        if (o_err[7] !== 1'b0 || o_err[8] !== 1'b1) begin
            n_fail++; $display("FAIL spacing_err: got %0b%0b expected 01", o_err[7], o_err[8]);
        end
        n_checks++;
        if (o_err[29] !== 1'b1) begin n_fail++; $display("FAIL spacing_sticky: got %0b expected 1", o_err[29]); end
        got = (pop_q.size() > 0) ? pop_q[0] : '0;
        n_checks++;
        if (pop_q.size() < 1 || got !== w1) begin
            n_fail++; $display("FAIL spacing_first_word: got %0h expected %0h", got, w1);
        end
    endtask

    task automatic test_reset_mid_tile();
        logic [WORD_W-1:0] e;
        logic [WORD_W-1:0] got;
        int                nvalid;
        do_reset();
        clear_sched();
        cur_sat = 1'b0;
        fill_rand(4);
        add_tile(1, 4, e);
        s_rst[6] = 1'b0;
        run(30);
        nvalid = 0;
        for (int c = 0; c < 30; c++) if (o_valid[c]) nvalid++;
        n_checks++;
        if (nvalid != 0) begin n_fail++; $display("FAIL midrst_valid: got %0d valid cycles expected 0", nvalid); end
        n_checks++;
        if (o_ovf[29] !== 1'b0 || o_err[29] !== 1'b0 || o_full[29] !== 1'b0) begin
            n_fail++; $display("FAIL midrst_flags: got ovf=%0b err=%0b full=%0b expected 0 0 0",
                               o_ovf[29], o_err[29], o_full[29]);
        end
        clear_sched();
        fill_rand(5);
        add_tile(1, 5, e);
        run(24);
        got = (pop_q.size() > 0) ? pop_q[0] : '0;
        n_checks++;
        if (pop_q.size() != 1 || got !== e) begin
            n_fail++; $display("FAIL midrst_next_tile: got %0h (%0d words) expected %0h", got, pop_q.size(), e);
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_wrap_sat();
        test_random();
        test_backpressure();
        test_push_pop_full();
        test_spacing();
        test_reset_mid_tile();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
